// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the decoder.
//   fetch_state_t  fetch-stage FSM states (INIT/RUN/DRAIN/HALT)
//   OPC_HALT       end-of-program opcode
//   HALT_WORD      terminator word returned by instruction memory
//   NOP_WORD       bubble inserted into IF/ID
//   INIT_PC        PC value during the reset/init cycle
package cpu_pkg;

  localparam logic [5:0]  OPC_HALT     = 6'b111111;
  localparam logic [31:0] HALT_WORD    = {OPC_HALT, 26'd0};
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] INIT_PC      = 32'hFFFF_FFFC;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    FS_INIT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with hold, clear-to-NOP and valid bit.
//   clk, rst    rising-edge clock, synchronous active-high reset
//   clear       load NOP_WORD / pc4=0 / valid=0 (wins over load)
//   load        capture instr and pc4, set valid
//   instr, pc4  values to capture
//   ifid_instr, ifid_pc4, ifid_valid  register outputs
// With neither clear nor load the register holds.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_VALUE = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ifid_instr <= NOP_VALUE;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_instr <= instr;
      ifid_pc4   <= pc4;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: MIPS instruction-fetch stage.
// Owns the PC, drives the instruction-memory address, fills IF/ID with the
// returned word and PC+4, and handles stall, flush and branch/jump redirects.
// On the end-of-program word it waits DRAIN_CYCLES cycles (so an older branch
// can still redirect) and then halts until reset.
//   clk, rst                      rising-edge clock, sync active-high reset
//   stall                         hold PC and IF/ID
//   flush                         replace IF/ID with a bubble
//   branch_taken, branch_target   resolved taken branch (beats jump)
//   jump, jump_target             jump decoded in ID
//   instr_addr                    address to instruction memory (= PC)
//   instr_in                      instruction word for instr_addr
//   ifid_instr, ifid_pc4, ifid_valid  IF/ID register
//   halted                        front end stopped
// Optional (`define FETCH_PERF_EN):
//   fetch_cnt  saturating count of edges writing a valid IF/ID entry
//   stall_cnt  saturating count of RUN edges stalled without redirect
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_WORD    = cpu_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD     = cpu_pkg::NOP_WORD,
  parameter logic [31:0] INIT_PC      = cpu_pkg::INIT_PC,
  parameter int unsigned DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [CW-1:0] drain_cnt;

  logic          redirect;
  logic [31:0]   target;
  logic [31:0]   pc_plus4;
  logic          halt_hit;
  logic          ifid_clear;
  logic          ifid_load;

  always_comb begin
    redirect = branch_taken || jump;
    target   = branch_taken ? branch_target : jump_target;
    target   = target & ~32'd3;
    pc_plus4 = pc + 32'd4;
    halt_hit = (instr_in == HALT_WORD);
  end

  // IF/ID control mirrors the RUN priority: redirect, flush, stall, halt word.
  // Outside RUN the register is kept at the bubble.
  always_comb begin
    ifid_clear = 1'b0;
    ifid_load  = 1'b0;
    if (state != FS_RUN) begin
      ifid_clear = 1'b1;
    end else if (redirect || flush) begin
      ifid_clear = 1'b1;
    end else if (!stall) begin
      if (halt_hit) ifid_clear = 1'b1;
      else          ifid_load  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= INIT_PC;
      state     <= FS_INIT;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        FS_INIT: begin
          pc    <= '0;
          state <= FS_RUN;
        end
        FS_RUN: begin
          if (redirect) begin
            pc <= target;
          end else if (stall) begin
            pc <= pc;
          end else if (flush) begin
            pc <= pc_plus4;
          end else if (halt_hit) begin
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
            state     <= FS_DRAIN;
          end else begin
            pc <= pc_plus4;
          end
        end
        FS_DRAIN: begin
          if (redirect) begin
            pc    <= target;
            state <= FS_RUN;
          end else if (drain_cnt == '0) begin
            state  <= FS_HALT;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        FS_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= FS_INIT;
        end
      endcase
    end
  end

  assign instr_addr = pc;

  ifid_reg #(
    .NOP_VALUE (NOP_WORD)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .clear      (ifid_clear),
    .load       (ifid_load),
    .instr      (instr_in),
    .pc4        (pc_plus4),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ifid_load && (fetch_cnt != '1))
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == FS_RUN) && stall && !redirect && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a combinational memory model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  localparam logic [31:0] HALTW = 32'hFC00_0000;

  always #5 clk = ~clk;

  always_comb begin
    if (instr_addr < 32'd256) instr_in = mem[instr_addr[7:2]];
    else                      instr_in = HALTW;
  end

  pc_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .instr_addr    (instr_addr),
    .instr_in      (instr_in),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = HALTW;
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_1000 + 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[4] = HALTW;  // end-of-program at 0x10

    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_addr",   instr_addr, 32'hFFFF_FFFC);
    check("rst_valid",  {31'd0, ifid_valid}, 32'd0);
    check("rst_instr",  ifid_instr, 32'h0);
    check("rst_pc4",    ifid_pc4, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_fcnt", fetch_cnt, 32'd0);
    check("rst_scnt", stall_cnt, 32'd0);
`endif

    rst = 1'b0;
    step();  // INIT cycle ends
    check("init_addr",  instr_addr, 32'h0);
    check("init_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check("f0_instr", ifid_instr, 32'h2008_0005);
    check("f0_pc4",   ifid_pc4, 32'h4);
    check("f0_valid", {31'd0, ifid_valid}, 32'd1);
    check("f0_addr",  instr_addr, 32'h4);
    step();
    check("f1_instr", ifid_instr, 32'h2009_0003);
    check("f1_pc4",   ifid_pc4, 32'h8);
    check("f1_addr",  instr_addr, 32'h8);

    // stall two cycles at PC=8
    stall = 1'b1;
    step();
    check("st1_addr",  instr_addr, 32'h8);
    check("st1_instr", ifid_instr, 32'h2009_0003);
    step();
    check("st2_addr",  instr_addr, 32'h8);
    check("st2_pc4",   ifid_pc4, 32'h8);
    stall = 1'b0;
    step();
    check("rel_addr",  instr_addr, 32'hC);
    check("rel_pc4",   ifid_pc4, 32'hC);
    check("rel_instr", ifid_instr, 32'h2000_1002);
`ifdef FETCH_PERF_EN
    check("perf_fcnt", fetch_cnt, 32'd3);
    check("perf_scnt", stall_cnt, 32'd2);
`endif

    // branch beats jump, redirect beats stall
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
    step();
    clear_inputs();
    check("bj_addr",  instr_addr, 32'h40);
    check("bj_instr", ifid_instr, 32'h0);
    check("bj_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check("b40_instr", ifid_instr, 32'h2000_1010);
    check("b40_pc4",   ifid_pc4, 32'h44);
    check("b40_addr",  instr_addr, 32'h44);

    // unaligned branch target is word-aligned
    branch_taken = 1'b1; branch_target = 32'h43;
    step();
    clear_inputs();
    check("bal_addr", instr_addr, 32'h40);

    // jump alone, unaligned
    jump = 1'b1; jump_target = 32'h22;
    step();
    clear_inputs();
    check("jmp_addr", instr_addr, 32'h20);

    // flush without stall: bubble, PC still advances
    step();
    check("pre_fl_pc4", ifid_pc4, 32'h24);
    flush = 1'b1;
    step();
    clear_inputs();
    check("fl_valid", {31'd0, ifid_valid}, 32'd0);
    check("fl_instr", ifid_instr, 32'h0);
    check("fl_addr",  instr_addr, 32'h28);

    // halt word at 0x10 -> DRAIN for 3 edges -> HALT
    jump = 1'b1; jump_target = 32'h10;
    step();
    clear_inputs();
    check("h_addr", instr_addr, 32'h10);
    step();  // enters DRAIN
    check("d0_addr",   instr_addr, 32'h10);
    check("d0_halted", {31'd0, halted}, 32'd0);
    check("d0_valid",  {31'd0, ifid_valid}, 32'd0);
    flush = 1'b1; stall = 1'b1;  // no effect in DRAIN
    step();
    clear_inputs();
    check("d1_halted", {31'd0, halted}, 32'd0);
    check("d1_addr",   instr_addr, 32'h10);
    step();
    check("d2_halted", {31'd0, halted}, 32'd0);
    step();
    check("d3_halted", {31'd0, halted}, 32'd1);
    check("d3_addr",   instr_addr, 32'h10);
    check("d3_valid",  {31'd0, ifid_valid}, 32'd0);

    // redirects ignored once halted
    branch_taken = 1'b1; branch_target = 32'h4;
    step();
    clear_inputs();
    check("hl_addr",   instr_addr, 32'h10);
    check("hl_halted", {31'd0, halted}, 32'd1);

    // reset from HALT
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rh_halted", {31'd0, halted}, 32'd0);
    check("rh_addr",   instr_addr, 32'hFFFF_FFFC);
    check("rh_valid",  {31'd0, ifid_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    check("rh_fcnt", fetch_cnt, 32'd0);
    check("rh_scnt", stall_cnt, 32'd0);
`endif
    step();
    check("rh_init_addr", instr_addr, 32'h0);

    // halt word again; branch during 2nd DRAIN cycle pulls back to RUN
    jump = 1'b1; jump_target = 32'h10;
    step();
    clear_inputs();
    check("r2_addr", instr_addr, 32'h10);
    step();  // DRAIN cycle 1
    step();  // DRAIN cycle 2
    check("r2_d_halted", {31'd0, halted}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h4;
    step();
    clear_inputs();
    check("r2_addr_back", instr_addr, 32'h4);
    check("r2_halted",    {31'd0, halted}, 32'd0);
    step();
    check("r2_instr", ifid_instr, 32'h2009_0003);
    check("r2_pc4",   ifid_pc4, 32'h8);
    check("r2_valid", {31'd0, ifid_valid}, 32'd1);
    step();
    step();
    check("r2_run_halted", {31'd0, halted}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
